mem_port_arbiter: RTL and testbench

- Shares one single-port memory between the core's instruction-fetch port and its data (load/store) port.
- Sits between the pipelined core and a unified instruction/data memory.
- Serialises accesses with at most one outstanding transaction.
- Uses fixed data-over-fetch priority, with a starvation guard for fetch.
- Routes each read response back to the requester that issued it.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the core's fetch
// port and its load/store port. One transaction is outstanding at a time;
// data has priority over fetch, but a pending fetch is granted after
// MAX_D_STREAK consecutive data grants. Read responses are routed back to
// the port that issued the request.
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req_valid,
  input  logic [DATA_WIDTH-1:0] i_req_addr,
  output logic                  i_req_ready,
  output logic                  i_rsp_valid,
  output logic [DATA_WIDTH-1:0] i_rsp_data,
  input  logic                  d_req_valid,
  input  logic [DATA_WIDTH-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  input  logic                  d_req_we,
  output logic                  d_req_ready,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic                  m_req_valid,
  output logic [DATA_WIDTH-1:0] m_req_addr,
  output logic [DATA_WIDTH-1:0] m_req_wdata,
  output logic                  m_req_we,
  input  logic                  m_req_ready,
  input  logic                  m_rsp_valid,
  input  logic [DATA_WIDTH-1:0] m_rsp_data
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  localparam logic       OWN_FETCH  = 1'b0;
  localparam logic       OWN_DATA   = 1'b1;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t                state;
  state_t                state_next;
  logic                  owner;
  logic [3:0]            streak;
  logic [3:0]            streak_next;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic                  grant_i;
  logic                  grant_d;

  // Arbitration, next state and streak update; grants only happen in IDLE.
  always_comb begin
    state_next  = state;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    streak_next = streak;
    case (state)
      IDLE: begin
        if (i_req_valid && d_req_valid) begin
          if (streak == STREAK_MAX) grant_i = 1'b1;
          else                      grant_d = 1'b1;
        end else begin
          grant_i = i_req_valid;
          grant_d = d_req_valid;
        end
        if (grant_i || grant_d) state_next = ISSUE;
        // Streak only counts data grants that overtook a waiting fetch.
        if (grant_i) begin
          streak_next = 4'd0;
        end else if (grant_d) begin
          if (!i_req_valid)               streak_next = 4'd0;
          else if (streak >= STREAK_MAX)  streak_next = STREAK_MAX;
          else                            streak_next = streak + 4'd1;
        end
      end
      ISSUE: begin
        // Stores complete on acceptance; loads and fetches await data.
        if (m_req_ready) state_next = we_q ? IDLE : WAIT_RSP;
      end
      WAIT_RSP: begin
        if (m_rsp_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;
  assign m_req_valid = (state == ISSUE);
  assign m_req_addr  = (state == ISSUE) ? addr_q  : '0;
  assign m_req_wdata = (state == ISSUE) ? wdata_q : '0;
  assign m_req_we    = (state == ISSUE) ? we_q    : 1'b0;

  // State register, streak counter and capture of the granted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      streak  <= 4'd0;
      owner   <= OWN_FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state  <= state_next;
      streak <= streak_next;
      if (grant_i) begin
        owner   <= OWN_FETCH;
        addr_q  <= i_req_addr;
        wdata_q <= '0;
        we_q    <= 1'b0;
      end else if (grant_d) begin
        owner   <= OWN_DATA;
        addr_q  <= d_req_addr;
        wdata_q <= d_req_wdata;
        we_q    <= d_req_we;
      end
    end
  end

  // Response routing: responses outside WAIT_RSP are stale and dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      i_rsp_data  <= '0;
      d_rsp_data  <= '0;
    end else begin
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      if ((state == WAIT_RSP) && m_rsp_valid) begin
        if (owner == OWN_DATA) begin
          d_rsp_valid <= 1'b1;
          d_rsp_data  <= m_rsp_data;
        end else begin
          i_rsp_valid <= 1'b1;
          i_rsp_data  <= m_rsp_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by a randomized
// run, checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req_valid, i_req_ready, i_rsp_valid;
  logic [DW-1:0] i_req_addr, i_rsp_data;
  logic          d_req_valid, d_req_we, d_req_ready, d_rsp_valid;
  logic [DW-1:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic          m_req_valid, m_req_we, m_req_ready, m_rsp_valid;
  logic [DW-1:0] m_req_addr, m_req_wdata, m_rsp_data;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(DW), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_req_we(d_req_we), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .m_req_valid(m_req_valid), .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata),
    .m_req_we(m_req_we), .m_req_ready(m_req_ready),
    .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data)
  );

  int checks = 0;
  int errors = 0;

  // Requesters: one pending request per port, held until accepted.
  bit          i_pend = 0, d_pend = 0, d_we_m = 0;
  logic [31:0] i_addr_m = '0, d_addr_m = '0, d_wdata_m = '0;
  // Outstanding transaction as seen by the model.
  bit          txn_act = 0, txn_acc = 0, txn_owner = 0, txn_we = 0;
  logic [31:0] txn_addr = '0, txn_wdata = '0;
  int          rsp_cnt = 0;
  int          streak = 0;
  // Expected response-port state.
  bit          exp_i_rv = 0, exp_d_rv = 0;
  logic [31:0] exp_i_rd = '0, exp_d_rd = '0;
  // Memory contents and stimulus knobs.
  logic [31:0] mem [logic [31:0]];
  int unsigned p_i = 0, p_d = 0, p_store = 0, p_mready = 100, p_stale = 0;
  int unsigned lat_min = 1, lat_max = 1;
  bit          force_stale = 0;
  logic [31:0] force_stale_data = '0;
  string       glog = "";
  int          mv_cycles = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_str(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: drive inputs, check outputs, advance the model.
  task automatic step();
    bit resp_now, gi, gd;
    @(negedge clk);
    i_req_valid = i_pend;
    i_req_addr  = i_pend ? i_addr_m : $urandom;
    d_req_valid = d_pend;
    d_req_addr  = d_pend ? d_addr_m : $urandom;
    d_req_wdata = d_pend ? d_wdata_m : $urandom;
    d_req_we    = d_pend ? d_we_m : 1'($urandom);
    m_req_ready = ($urandom_range(0, 99) < p_mready);
    resp_now    = txn_act && txn_acc && (rsp_cnt == 0);
    m_rsp_valid = 1'b0;
    m_rsp_data  = $urandom;
    if (resp_now) begin
      m_rsp_valid = 1'b1;
      m_rsp_data  = mem_rd(txn_addr);
    end else if (!txn_act || (!txn_acc && !m_req_ready)) begin
      if (force_stale) begin
        m_rsp_valid = 1'b1;
        m_rsp_data  = force_stale_data;
        force_stale = 0;
      end else if ($urandom_range(0, 99) < p_stale) begin
        m_rsp_valid = 1'b1;
      end
    end
    #1;
    gi = 0;
    gd = 0;
    if (!txn_act) begin
      if (i_pend && d_pend) begin
        if (streak == MAXS) gi = 1;
        else                gd = 1;
      end else begin
        gi = i_pend;
        gd = d_pend;
      end
    end
    chk("i_req_ready", 32'(i_req_ready), 32'(gi));
    chk("d_req_ready", 32'(d_req_ready), 32'(gd));
    chk("m_req_valid", 32'(m_req_valid), 32'(txn_act && !txn_acc));
    if (txn_act && !txn_acc) begin
      chk("m_req_addr", m_req_addr, txn_addr);
      chk("m_req_we", 32'(m_req_we), 32'(txn_we));
      if (txn_we || !txn_owner) chk("m_req_wdata", m_req_wdata, txn_wdata);
    end
    if (m_req_valid) mv_cycles++;
    chk("i_rsp_valid", 32'(i_rsp_valid), 32'(exp_i_rv));
    chk("d_rsp_valid", 32'(d_rsp_valid), 32'(exp_d_rv));
    chk("i_rsp_data", i_rsp_data, exp_i_rd);
    chk("d_rsp_data", d_rsp_data, exp_d_rd);
    // Advance the model across the coming rising edge.
    exp_i_rv = 0;
    exp_d_rv = 0;
    if (resp_now) begin
      if (txn_owner) begin exp_d_rv = 1; exp_d_rd = m_rsp_data; end
      else           begin exp_i_rv = 1; exp_i_rd = m_rsp_data; end
      txn_act = 0;
    end else if (txn_act && !txn_acc && m_req_ready) begin
      if (txn_we) begin
        mem[txn_addr] = txn_wdata;
        txn_act = 0;
      end else begin
        txn_acc = 1;
        rsp_cnt = int'($urandom_range(lat_min, lat_max)) - 1;
      end
    end else if (txn_act && txn_acc) begin
      rsp_cnt--;
    end
    if (gi) begin
      txn_act = 1; txn_acc = 0; txn_owner = 0;
      txn_addr = i_addr_m; txn_we = 0; txn_wdata = '0;
      i_pend = 0; streak = 0;
      glog = {glog, "I"};
    end
    if (gd) begin
      txn_act = 1; txn_acc = 0; txn_owner = 1;
      txn_addr = d_addr_m; txn_we = d_we_m; txn_wdata = d_wdata_m;
      d_pend = 0;
      streak = i_pend ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
      glog = {glog, "D"};
    end
    if (!i_pend && ($urandom_range(0, 99) < p_i)) begin
      i_pend   = 1;
      i_addr_m = 32'h100 + 32'(4 * $urandom_range(0, 15));
    end
    if (!d_pend && ($urandom_range(0, 99) < p_d)) begin
      d_pend    = 1;
      d_addr_m  = 32'h40 + 32'(4 * $urandom_range(0, 7));
      d_we_m    = ($urandom_range(0, 99) < p_store);
      d_wdata_m = $urandom;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    i_req_valid = 0; d_req_valid = 0; d_req_we = 0;
    m_req_ready = 0; m_rsp_valid = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    i_pend = 0; d_pend = 0;
    txn_act = 0; txn_acc = 0; rsp_cnt = 0; streak = 0;
    exp_i_rv = 0; exp_d_rv = 0; exp_i_rd = '0; exp_d_rd = '0;
    glog = "";
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    i_req_valid = 0; d_req_valid = 0; d_req_we = 0;
    m_req_ready = 0; m_rsp_valid = 0;
    #1;
    chk({tag, "_i_req_ready"}, 32'(i_req_ready), 32'd0);
    chk({tag, "_d_req_ready"}, 32'(d_req_ready), 32'd0);
    chk({tag, "_i_rsp_valid"}, 32'(i_rsp_valid), 32'd0);
    chk({tag, "_d_rsp_valid"}, 32'(d_rsp_valid), 32'd0);
    chk({tag, "_i_rsp_data"}, i_rsp_data, 32'd0);
    chk({tag, "_d_rsp_data"}, d_rsp_data, 32'd0);
    chk({tag, "_m_req_valid"}, 32'(m_req_valid), 32'd0);
    chk({tag, "_m_req_we"}, 32'(m_req_we), 32'd0);
    chk({tag, "_m_req_addr"}, m_req_addr, 32'd0);
    chk({tag, "_m_req_wdata"}, m_req_wdata, 32'd0);
  endtask

  task automatic run_until(input int n, input int bound);
    int k = 0;
    while (glog.len() < n && k < bound) begin
      step();
      k++;
    end
    chk("grant_count", 32'(glog.len()), 32'(n));
  endtask

  initial begin
    reset = 1'b1;
    i_req_valid = 0; i_req_addr = '0;
    d_req_valid = 0; d_req_addr = '0; d_req_wdata = '0; d_req_we = 0;
    m_req_ready = 0; m_rsp_valid = 0; m_rsp_data = '0;
    repeat (2) @(posedge clk);
    do_reset();
    check_reset_outputs("reset");

    // Lone fetch with immediate acceptance and one-cycle memory latency.
    mem[32'h100] = 32'hDEADBEEF;
    p_mready = 100; lat_min = 1; lat_max = 1;
    i_pend = 1; i_addr_m = 32'h100;
    repeat (6) step();
    chk_str("lone_fetch_grants", glog, "I");
    chk("lone_fetch_data", i_rsp_data, 32'hDEADBEEF);

    // Store held off by the memory for three cycles.
    glog = ""; mv_cycles = 0;
    d_pend = 1; d_addr_m = 32'h40; d_we_m = 1; d_wdata_m = 32'h12345678;
    p_mready = 0;
    repeat (4) step();
    p_mready = 100;
    repeat (3) step();
    chk("store_mreq_cycles", 32'(mv_cycles), 32'd4);
    chk_str("store_grants", glog, "D");

    // Continuous contention, loads only: starvation guard every 5th grant.
    do_reset();
    p_i = 100; p_d = 100; p_store = 0; lat_min = 1; lat_max = 3;
    i_pend = 1; i_addr_m = 32'h104;
    d_pend = 1; d_addr_m = 32'h44; d_we_m = 0; d_wdata_m = $urandom;
    run_until(10, 300);
    chk_str("contention_order", glog, "DDDDIDDDDI");

    // Streak restarts after a data grant made with no fetch waiting.
    do_reset();
    p_i = 0; p_d = 100; p_store = 0;
    i_pend = 1; i_addr_m = 32'h108;
    d_pend = 1; d_addr_m = 32'h48; d_we_m = 0; d_wdata_m = $urandom;
    run_until(3, 100);
    i_pend = 0;
    run_until(4, 100);
    i_pend = 1; i_addr_m = 32'h10C; p_i = 100;
    run_until(9, 200);
    chk_str("streak_restart", glog, "DDDDDDDDI");

    // Reset while waiting for read data, then a late response arrives.
    do_reset();
    p_i = 0; p_d = 0; lat_min = 6; lat_max = 6; p_mready = 100;
    d_pend = 1; d_addr_m = 32'h48; d_we_m = 0; d_wdata_m = '0;
    for (int k = 0; k < 20 && !txn_acc; k++) step();
    step();
    do_reset();
    force_stale = 1; force_stale_data = 32'hAAAA5555;
    step();
    check_reset_outputs("after_stale");
    lat_min = 1; lat_max = 2;
    i_pend = 1; i_addr_m = 32'h100;
    repeat (8) step();
    chk_str("post_reset_grants", glog, "I");
    chk("post_reset_fetch_data", i_rsp_data, 32'hDEADBEEF);

    // Randomized traffic with back-pressure, variable latency, stale pulses.
    do_reset();
    p_i = 40; p_d = 50; p_store = 35; p_mready = 60;
    lat_min = 1; lat_max = 4; p_stale = 15;
    repeat (3000) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
